// File: rtl/tick_sched_pkg.sv
// Shared types and default sizing for the tick scheduler.
package tick_sched_pkg;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned CH_W  = $clog2(NCH);

  typedef enum logic {
    IDLE,
    PEND
  } cfg_state_e;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [DIV_W-1:0] div;
  } pend_req_t;

endpackage

// File: rtl/tick_sched_if.sv
// Configuration handshake and tick/toggle outputs of the tick scheduler.
interface tick_sched_if;
  import tick_sched_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_en;
  logic             sync;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   tgl;
  logic             busy;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_en, sync,
    input  cfg_ready, tick, tgl, busy
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_en, sync,
    output cfg_ready, tick, tgl, busy
  );
endinterface

// File: rtl/tick_sched_chan.sv
// One tick channel: divisor, wrap counter, single-cycle tick and toggle output.
module tick_chan
  import tick_sched_pkg::*;
(
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             reload_i,
  input  logic             sync_i,
  input  logic             cnt_en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             en_o,
  output logic             wrap_c_o,
  output logic             tick_o,
  output logic             tgl_o
);

  logic             en_q, en_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             tgl_q, tgl_d;
  logic             wrap_c;

  assign wrap_c = en_q & cnt_en_i & (cnt_q == (div_q - DIV_W'(1)));

  // Stop beats start beats sync beats wrap; a reload rides on whichever edge releases it.
  always_comb begin
    en_d   = en_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    tgl_d  = tgl_q;
    if (stop_i) begin
      en_d  = 1'b0;
      cnt_d = '0;
      tgl_d = 1'b0;
    end else if (start_i) begin
      en_d  = 1'b1;
      div_d = div_i;
      cnt_d = '0;
    end else if (en_q) begin
      if (reload_i) div_d = div_i;
      if (sync_i) begin
        cnt_d = '0;
      end else if (wrap_c) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        tgl_d  = ~tgl_q;
      end else if (cnt_en_i) begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      en_q   <= 1'b0;
      div_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      tgl_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      tgl_q  <= tgl_d;
    end
  end

  assign en_o     = en_q;
  assign wrap_c_o = wrap_c;
  assign tick_o   = tick_q;
  assign tgl_o    = tgl_q;

endmodule

// File: rtl/tick_sched.sv
// Tick scheduler top: config FSM with deferred reload plus NCH tick channels.
// TICK_SCHED_CASCADE_EN: last channel counts tick[0] strobes instead of sys_clk.
module tick_sched
  import tick_sched_pkg::*;
(
  input logic         sys_clk,
  input logic         reset,
  tick_sched_if.slave cfg_bus
);

  cfg_state_e       state_q, state_d;
  pend_req_t        pend_q, pend_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [NCH-1:0]   sel_c, start_c, stop_c, reload_c, wrap_c, en_c;
  logic [NCH-1:0]   tick_w, tgl_w;
  logic [DIV_W-1:0] chan_div_c;

  // Out-of-range channel numbers shift out to an empty select and are dropped.
  assign sel_c      = NCH'(1) << cfg_bus.cfg_ch;
  assign chan_div_c = (state_q == PEND) ? pend_q.div : cfg_bus.cfg_div;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    start_c  = '0;
    stop_c   = '0;
    reload_c = '0;
    case (state_q)
      IDLE: begin
        if (cfg_bus.cfg_valid) begin
          if (!cfg_bus.cfg_en || (cfg_bus.cfg_div == '0)) begin
            stop_c = sel_c;
          end else if (|(sel_c & en_c)) begin
            pend_d  = '{ch: cfg_bus.cfg_ch, div: cfg_bus.cfg_div};
            state_d = PEND;
          end else begin
            start_c = sel_c;
          end
        end
      end
      PEND: begin
        if (wrap_c[pend_q.ch] || cfg_bus.sync) begin
          reload_c[pend_q.ch] = 1'b1;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == PEND);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
    logic cnt_en;
`ifdef TICK_SCHED_CASCADE_EN
    if (i == int'(NCH) - 1) begin : g_casc
      assign cnt_en = tick_w[0];
    end else begin : g_free
      assign cnt_en = 1'b1;
    end
`else
    assign cnt_en = 1'b1;
`endif
    tick_chan u_chan (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .start_i  (start_c[i]),
      .stop_i   (stop_c[i]),
      .reload_i (reload_c[i]),
      .sync_i   (cfg_bus.sync),
      .cnt_en_i (cnt_en),
      .div_i    (chan_div_c),
      .en_o     (en_c[i]),
      .wrap_c_o (wrap_c[i]),
      .tick_o   (tick_w[i]),
      .tgl_o    (tgl_w[i])
    );
  end

  assign cfg_bus.cfg_ready = ready_q;
  assign cfg_bus.busy      = busy_q;
  assign cfg_bus.tick      = tick_w;
  assign cfg_bus.tgl       = tgl_w;

endmodule
